// File: rtl/cv32e41p_pkg.sv
// Shared definitions for the register-file writeback path: requester
// indices used to address grant vectors and the round-robin encoding.
package cv32e41p_pkg;

    // Requester indices into the per-producer grant vector
    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_MD  = 2;
    localparam int WB_NUM = 3;

    // Round-robin pointer: names the requester favoured for port A
    typedef enum logic {
        RR_ALU = 1'b0,
        RR_MD  = 1'b1
    } wb_rr_e;

endpackage

// File: rtl/cv32e41p_rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Set by ID when it issues an instruction with a destination, cleared by
// the writeback ports when the result lands. Register 0 is never busy.
module cv32e41p_rf_scoreboard
    import cv32e41p_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_valid_i,
    input  logic [ADDR_WIDTH-1:0] set_addr_i,
    input  logic                  clr_a_valid_i,
    input  logic [ADDR_WIDTH-1:0] clr_a_addr_i,
    input  logic                  clr_b_valid_i,
    input  logic [ADDR_WIDTH-1:0] clr_b_addr_i,
    output logic [NUM_REGS-1:0]   busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Apply both clears first and the set last, so an alloc landing in the
    // same cycle as an older write to the same register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (clr_a_valid_i && (clr_a_addr_i == ADDR_WIDTH'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (clr_b_valid_i && (clr_b_addr_i == ADDR_WIDTH'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (set_valid_i && (set_addr_i == ADDR_WIDTH'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Busy flops, cleared asynchronously so hazards vanish with the pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/cv32e41p_rf_wb_arbiter.sv
// Writeback arbiter in front of the two-write-port register file.
// ALU and MULDIV share port A through a round-robin pointer; the LSU always
// takes port B when it has a result, otherwise the round-robin loser uses it.
// A same-register collision between the two chosen writes lets only one
// through so the register file never sees two writes to one address.
module cv32e41p_rf_wb_arbiter
    import cv32e41p_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  alu_valid_i,
    input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
    input  logic [DATA_WIDTH-1:0] alu_wdata_i,
    output logic                  alu_ready_o,

    input  logic                  lsu_valid_i,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  lsu_ready_o,

    input  logic                  md_valid_i,
    input  logic [ADDR_WIDTH-1:0] md_waddr_i,
    input  logic [DATA_WIDTH-1:0] md_wdata_i,
    output logic                  md_ready_o,

    output logic                  we_a_o,
    output logic [ADDR_WIDTH-1:0] waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,

    output logic                  we_b_o,
    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o,

    input  logic                  alloc_valid_i,
    input  logic [ADDR_WIDTH-1:0] alloc_addr_i,
    output logic [NUM_REGS-1:0]   busy_o
);

    wb_rr_e rr_q;
    wb_rr_e rr_d;

    logic                  aluValid;
    logic                  lsuValid;
    logic                  mdValid;

    logic                  winnerIsMd;
    logic                  winnerValid;
    logic [ADDR_WIDTH-1:0] winnerAddr;
    logic [DATA_WIDTH-1:0] winnerData;

    logic                  loserValid;
    logic [ADDR_WIDTH-1:0] loserAddr;
    logic [DATA_WIDTH-1:0] loserData;

    logic                  portBIsLsu;
    logic                  portBValid;
    logic [ADDR_WIDTH-1:0] portBAddr;
    logic [DATA_WIDTH-1:0] portBData;

    logic                  addrConflict;
    logic                  grantA;
    logic                  grantB;
    logic                  weA;
    logic                  weB;
    logic [WB_NUM-1:0]     grant;

    // Pick the port-A winner and port-B candidate; reset masks every request
    // so nothing is accepted or written while rst is high.
    always_comb begin
        aluValid    = alu_valid_i & ~rst;
        lsuValid    = lsu_valid_i & ~rst;
        mdValid     = md_valid_i  & ~rst;

        winnerIsMd  = mdValid & ((rr_q == RR_MD) | ~aluValid);
        winnerValid = aluValid | mdValid;
        winnerAddr  = winnerIsMd ? md_waddr_i : alu_waddr_i;
        winnerData  = winnerIsMd ? md_wdata_i : alu_wdata_i;

        loserValid  = aluValid & mdValid;
        loserAddr   = winnerIsMd ? alu_waddr_i : md_waddr_i;
        loserData   = winnerIsMd ? alu_wdata_i : md_wdata_i;

        portBIsLsu  = lsuValid;
        portBValid  = lsuValid | loserValid;
        portBAddr   = lsuValid ? lsu_waddr_i : loserAddr;
        portBData   = lsuValid ? lsu_wdata_i : loserData;
    end

    // Resolve a same-register collision: the LSU always wins port B,
    // otherwise the round-robin winner on port A keeps its slot.
    always_comb begin
        addrConflict = winnerValid & portBValid &
                       (winnerAddr == portBAddr) & (winnerAddr != '0);
        grantA       = winnerValid & ~(addrConflict & portBIsLsu);
        grantB       = portBValid  & ~(addrConflict & ~portBIsLsu);

        grant          = '0;
        grant[WB_LSU]  = grantB & portBIsLsu;
        grant[WB_ALU]  = (grantA & ~winnerIsMd) | (grantB & ~portBIsLsu &  winnerIsMd);
        grant[WB_MD]   = (grantA &  winnerIsMd) | (grantB & ~portBIsLsu & ~winnerIsMd);
    end

    // Drive the register-file ports; address 0 is accepted but never written
    always_comb begin
        weA       = grantA & (winnerAddr != '0);
        weB       = grantB & (portBAddr  != '0);
        we_a_o    = weA;
        waddr_a_o = weA ? winnerAddr : '0;
        wdata_a_o = weA ? winnerData : '0;
        we_b_o    = weB;
        waddr_b_o = weB ? portBAddr  : '0;
        wdata_b_o = weB ? portBData  : '0;
    end

    assign alu_ready_o = grant[WB_ALU];
    assign lsu_ready_o = grant[WB_LSU];
    assign md_ready_o  = grant[WB_MD];

    // Hand port-A priority to the other requester whenever the winner lands
    always_comb begin
        rr_d = rr_q;
        if (grantA) begin
            rr_d = winnerIsMd ? RR_ALU : RR_MD;
        end
    end

    // Round-robin pointer; reset favours the ALU
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= RR_ALU;
        end else begin
            rr_q <= rr_d;
        end
    end

    cv32e41p_rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .set_valid_i   (alloc_valid_i),
        .set_addr_i    (alloc_addr_i),
        .clr_a_valid_i (weA),
        .clr_a_addr_i  (winnerAddr),
        .clr_b_valid_i (weB),
        .clr_b_addr_i  (portBAddr),
        .busy_o        (busy_o)
    );

endmodule
